uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It accepts each received byte on a single-cycle valid pulse, stores it in a first-word-fall-through FIFO, and presents it to the consumer over a ready/valid interface. It also provides a fill level, a threshold interrupt, and sticky overrun reporting, so that software or a host bus can drain bytes in bursts without losing any.

---
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Purpose : receive-side byte FIFO behind the UART receiver.
//           It is first-word-fall-through and reports fill level, a threshold
//           interrupt and sticky overrun status.
// Latency : a byte pushed in cycle N is on m_data with m_valid=1 in cycle N+1.
//           There is no same-cycle bypass.
// Backpressure: none toward the receiver, which cannot be stalled. A byte that
//           arrives while the FIFO is full and not being popped is dropped and
//           counted. The consumer side is plain ready/valid.
//
// Ports:
//   clk_in, rst             clock; synchronous active-high reset
//   rx_data, rx_valid       push side: one byte per single-cycle pulse
//   m_data, m_valid,
//   m_ready                 pop side: head byte, non-empty flag, consumer accept
//   level, full             stored byte count (0..2**DEPTH_LOG2) and full flag
//   thresh_irq              level >= THRESHOLD
//   overrun, overrun_count  sticky drop flag and saturating drop counter
//   clr_overrun             clears overrun and overrun_count
//   timeout_irq             idle-data interrupt
//
// Build option: define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout
// counter. Without that macro, timeout_irq is tied low.

module uart_rx_fifo #(
   parameter int DEPTH_LOG2     = 4,
   parameter int THRESHOLD      = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  thresh_irq,
   output logic                  overrun,
   output logic [7:0]            overrun_count,
   input  logic                  clr_overrun,
   output logic                  timeout_irq
);

   localparam int                   DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]  LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]  LVL_THR  = (DEPTH_LOG2+1)'(THRESHOLD);
   localparam logic [DEPTH_LOG2:0]  LVL_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0]  LVL_ZERO = '0;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   // Storage and state
   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic [7:0]            r_m_data;
   logic                  r_m_valid;
   logic                  r_full;
   logic                  r_thresh;
   logic                  r_overrun;
   logic [7:0]            r_ovr_cnt;

   // Next-state helpers
   logic                  w_pop;
   logic                  w_push_acc;
   logic                  w_drop;
   logic [DEPTH_LOG2-1:0] w_rd_next;
   logic [DEPTH_LOG2-1:0] w_wr_next;
   logic [DEPTH_LOG2:0]   w_level_next;
   logic [7:0]            w_m_data_next;

   // m_valid is exactly (level != 0), so popping on the registered flag
   // ignores a pop request against an empty FIFO.
   assign w_pop      = r_m_valid & m_ready;
   // When the FIFO is full, a simultaneous pop frees the slot the push needs.
   assign w_push_acc = rx_valid & (~r_full | w_pop);
   assign w_drop     = rx_valid & r_full & ~w_pop;

   assign w_rd_next  = w_pop      ? r_rd_ptr + PTR_ONE : r_rd_ptr;
   assign w_wr_next  = w_push_acc ? r_wr_ptr + PTR_ONE : r_wr_ptr;

   always_comb begin
      w_level_next = r_level;
      case ({w_push_acc, w_pop})
         2'b10:   w_level_next = r_level + LVL_ONE;
         2'b01:   w_level_next = r_level - LVL_ONE;
         default: w_level_next = r_level;
      endcase
   end

   // m_data is registered, so it must be loaded with the byte that will sit
   // at the new read pointer. If that slot is the one being written in this
   // cycle (empty FIFO, or a single byte being replaced), the incoming byte
   // is taken directly. Otherwise the head is read from the array.
   always_comb begin
      w_m_data_next = r_mem[w_rd_next];
      if (w_push_acc && (w_rd_next == r_wr_ptr)) begin
         w_m_data_next = rx_data;
      end
   end

   // The array has no reset. Stale contents are never visible because
   // m_valid gates them.
   always_ff @(posedge clk_in) begin
      if (!rst && w_push_acc) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_m_data  <= 8'h00;
         r_m_valid <= 1'b0;
         r_full    <= 1'b0;
         r_thresh  <= 1'b0;
      end else begin
         r_wr_ptr  <= w_wr_next;
         r_rd_ptr  <= w_rd_next;
         r_level   <= w_level_next;
         r_m_data  <= w_m_data_next;
         r_m_valid <= (w_level_next != LVL_ZERO);
         r_full    <= (w_level_next == LVL_FULL);
         r_thresh  <= (w_level_next >= LVL_THR);
      end
   end

   // A drop in the same cycle as a clear takes priority, so the dropped
   // byte is never lost from the count: the count restarts at 1.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_overrun <= 1'b0;
         r_ovr_cnt <= 8'h00;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
         if (clr_overrun) begin
            r_ovr_cnt <= 8'h01;
         end else if (r_ovr_cnt != 8'hFF) begin
            r_ovr_cnt <= r_ovr_cnt + 8'h01;
         end
      end else if (clr_overrun) begin
         r_overrun <= 1'b0;
         r_ovr_cnt <= 8'h00;
      end
   end

`ifdef UART_RX_FIFO_TIMEOUT_EN
   // Idle timer. It counts cycles in which data is stored but nothing moves,
   // and raises timeout_irq when a short burst sits below THRESHOLD for too
   // long.
   localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_ONE = TW'(1);

   logic [TW-1:0] r_to_cnt;
   logic          r_timeout;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (rx_valid || w_pop || (r_level == LVL_ZERO)) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (r_to_cnt != TO_MAX) begin
         r_to_cnt <= r_to_cnt + TO_ONE;
         // The flag rises on the same edge at which the count reaches the
         // limit. The count then holds there until activity resumes.
         if ((r_to_cnt + TO_ONE) == TO_MAX) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign timeout_irq = r_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timeout_irq      = 1'b0;
`endif

   assign m_data        = r_m_data;
   assign m_valid       = r_m_valid;
   assign level         = r_level;
   assign full          = r_full;
   assign thresh_irq    = r_thresh;
   assign overrun       = r_overrun;
   assign overrun_count = r_ovr_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : directed self-checking bench for uart_rx_fifo (16 deep, threshold 8).
// Latency : checks are taken 1 ns after each rising edge, once registered
//           outputs have settled.
// Backpressure: the bench drives m_ready explicitly in each scenario.

module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int TO_CYC = 20;
`else
   localparam int TO_CYC = 1000;
`endif

   logic       clk_in;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [4:0] level;
   logic       full;
   logic       thresh_irq;
   logic       overrun;
   logic [7:0] overrun_count;
   logic       clr_overrun;
   logic       timeout_irq;

   int n_chk = 0;
   int n_err = 0;

   uart_rx_fifo #(
      .DEPTH_LOG2     (4),
      .THRESHOLD      (8),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk_in        (clk_in),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .level         (level),
      .full          (full),
      .thresh_irq    (thresh_irq),
      .overrun       (overrun),
      .overrun_count (overrun_count),
      .clr_overrun   (clr_overrun),
      .timeout_irq   (timeout_irq)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      rx_valid = 1'b1;
      rx_data  = d;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] exp1 [3];
      exp1[0] = 8'h55; exp1[1] = 8'hA3; exp1[2] = 8'h0F;

      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
      m_ready = 1'b0; clr_overrun = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_level",   32'(level), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_full",    32'(full), 0);
      chk("rst_thresh",  32'(thresh_irq), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_ovr_cnt", 32'(overrun_count), 0);
      chk("rst_m_data",  32'(m_data), 32'h00);
      chk("rst_timeout", 32'(timeout_irq), 0);

      // 1: three pushes, then an in-order drain
      push(8'h55);
      chk("t1_first_valid", 32'(m_valid), 1);
      chk("t1_first_data",  32'(m_data), 32'h55);
      push(8'hA3);
      push(8'h0F);
      chk("t1_level3", 32'(level), 3);
      chk("t1_thresh", 32'(thresh_irq), 0);
      chk("t1_head",   32'(m_data), 32'h55);
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t1_out%0d", i), 32'(m_data), 32'(exp1[i]));
         tick();
      end
      m_ready = 1'b0;
      chk("t1_empty_valid", 32'(m_valid), 0);
      chk("t1_empty_level", 32'(level), 0);

      // 2: fill, threshold, overrun, clear
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk($sformatf("t2_thresh_lvl%0d", i + 1), 32'(thresh_irq), (i + 1 >= 8) ? 1 : 0);
      end
      chk("t2_full",  32'(full), 1);
      chk("t2_level", 32'(level), 16);
      push(8'hEE);
      push(8'hEF);
      chk("t2_overrun",  32'(overrun), 1);
      chk("t2_ovr_cnt",  32'(overrun_count), 2);
      chk("t2_level_kept", 32'(level), 16);
      chk("t2_head_kept",  32'(m_data), 32'h00);
      clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
      chk("t2_clr_overrun", 32'(overrun), 0);
      chk("t2_clr_cnt",     32'(overrun_count), 0);

      // 3: push and pop together while full
      rx_valid = 1'b1; rx_data = 8'h77; m_ready = 1'b1;
      tick();
      rx_valid = 1'b0; m_ready = 1'b0;
      chk("t3_level",   32'(level), 16);
      chk("t3_full",    32'(full), 1);
      chk("t3_overrun", 32'(overrun), 0);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t3_out%0d", i), 32'(m_data), (i < 15) ? 32'(i + 1) : 32'h77);
         tick();
      end
      m_ready = 1'b0;
      chk("t3_drained", 32'(level), 0);

      // 4: push and pop together while empty
      rx_valid = 1'b1; rx_data = 8'h3C; m_ready = 1'b1;
      tick();
      rx_valid = 1'b0; m_ready = 1'b0;
      chk("t4_level", 32'(level), 1);
      chk("t4_valid", 32'(m_valid), 1);
      chk("t4_data",  32'(m_data), 32'h3C);
      m_ready = 1'b1; tick(); m_ready = 1'b0;
      chk("t4_popped", 32'(level), 0);

      // Drop and clear in the same cycle, then saturation of the count
      for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
      rx_valid = 1'b1; rx_data = 8'hDD; clr_overrun = 1'b1;
      tick();
      rx_valid = 1'b0; clr_overrun = 1'b0;
      chk("drop_wins_flag", 32'(overrun), 1);
      chk("drop_wins_cnt",  32'(overrun_count), 1);
      rx_valid = 1'b1;
      for (int i = 0; i < 260; i++) tick();
      rx_valid = 1'b0;
      chk("ovr_saturate", 32'(overrun_count), 255);

      // 5: reset in the middle of a stream
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      chk("t5_level5", 32'(level), 5);
      rx_valid = 1'b1; rx_data = 8'h99; rst = 1'b1;
      tick();
      rx_valid = 1'b0; rst = 1'b0;
      chk("t5_level",   32'(level), 0);
      chk("t5_valid",   32'(m_valid), 0);
      chk("t5_overrun", 32'(overrun), 0);
      tick();
      chk("t5_not_stored", 32'(level), 0);
      push(8'h42);
      chk("t5_fresh_data", 32'(m_data), 32'h42);

      // 6: idle timeout with one byte stored
`ifdef UART_RX_FIFO_TIMEOUT_EN
      for (int i = 0; i < 19; i++) tick();
      chk("t6_before", 32'(timeout_irq), 0);
      tick();
      chk("t6_fired", 32'(timeout_irq), 1);
      tick(); tick();
      chk("t6_held", 32'(timeout_irq), 1);
      m_ready = 1'b1; tick(); m_ready = 1'b0;
      chk("t6_cleared", 32'(timeout_irq), 0);
`else
      for (int i = 0; i < 25; i++) tick();
      chk("t6_tied_low", 32'(timeout_irq), 0);
      m_ready = 1'b1; tick(); m_ready = 1'b0;
      chk("t6_tied_low_after_pop", 32'(timeout_irq), 0);
`endif
      chk("t6_empty", 32'(level), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
